// File: rtl/palette_pkg.sv
// Shared types and default colour table for the palette LUT.
package palette_pkg;

  localparam int PAL_COLOR_W = 24;
  localparam int PAL_N_DEF   = 16;

  typedef logic [PAL_COLOR_W-1:0] color_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } palette_state_e;

  localparam color_t DEFAULT_PALETTE [PAL_N_DEF] = '{
    24'hA056FF, 24'h00FF00, 24'h6700FF, 24'hFFA000,
    24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF,
    24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF,
    24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF
  };

  function automatic color_t default_color(input int idx);
    if (idx >= 0 && idx < PAL_N_DEF) return DEFAULT_PALETTE[idx[3:0]];
    return '0;
  endfunction

endpackage

// File: rtl/palette_rd_port.sv
// One registered palette read channel: range check plus same-cycle write forwarding.
module palette_rd_port #(
  parameter int COLOR_W = 24,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          accept,
  input  logic [IDX_W-1:0]              idx,
  input  logic [DEPTH-1:0][COLOR_W-1:0] mem,
  input  logic                          wr_fire,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [COLOR_W-1:0]            wr_data,
  output logic [COLOR_W-1:0]            data,
  output logic                          data_valid
);

  localparam logic [IDX_W:0] DEPTH_C = DEPTH[IDX_W:0];

  logic               in_range;
  logic               fwd;
  logic [COLOR_W-1:0] word;

  assign in_range = {1'b0, idx} < DEPTH_C;
  // An out-of-range write is discarded, so it must not forward either.
  assign fwd      = wr_fire && (wr_idx == idx) && in_range;
  assign word     = fwd ? wr_data : (in_range ? mem[idx] : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= accept;
      if (accept) data <= word;
    end
  end

endmodule

// File: rtl/palette_lut.sv
// Reprogrammable colour palette with N_RD registered read channels and an init sequencer.
// Optional host write port enabled by defining PALETTE_WR_EN.
module palette_lut
  import palette_pkg::*;
#(
  parameter int COLOR_W = 24,
  parameter int DEPTH   = 16,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int N_RD    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    restore,
  output logic                    busy,
  input  logic [N_RD-1:0]         rd_valid,
  input  logic [N_RD*IDX_W-1:0]   rd_idx,
  output logic                    rd_ready,
  output logic [N_RD*COLOR_W-1:0] rd_data,
  output logic [N_RD-1:0]         rd_data_valid,
  input  logic                    wr_valid,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [COLOR_W-1:0]      wr_data,
  output logic                    wr_ready
);

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_C = DEPTH[IDX_W:0];

  palette_state_e               state_q, state_d;
  logic [IDX_W-1:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0][COLOR_W-1:0] mem;
  logic                         accept_ok;
  logic                         wr_fire;
  logic                         wr_in_range;

  // Default table is stored MSB-aligned: narrower words drop LSBs, wider ones pad LSBs with zeros.
  function automatic logic [COLOR_W-1:0] fit_color(input color_t c);
    logic [COLOR_W+PAL_COLOR_W-1:0] wide;
    wide = {c, {COLOR_W{1'b0}}};
    return wide[COLOR_W+PAL_COLOR_W-1 -: COLOR_W];
  endfunction

  assign busy      = (state_q == INIT);
  assign rd_ready  = !busy;
  // The restore cycle itself accepts nothing, even though ready is still high.
  assign accept_ok = !busy && !restore;

`ifdef PALETTE_WR_EN
  assign wr_ready = !busy;
  assign wr_fire  = wr_valid && accept_ok;
`else
  logic unused_wr;
  assign wr_ready  = 1'b0;
  assign wr_fire   = 1'b0;
  assign unused_wr = wr_valid;
`endif

  assign wr_in_range = {1'b0, wr_idx} < DEPTH_C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (restore) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Storage is deliberately left unreset; the sequencer fills it after every reset.
  always_ff @(posedge clk) begin
    if (busy) mem[cnt_q] <= fit_color(default_color(int'(cnt_q)));
    else if (wr_fire && wr_in_range) mem[wr_idx] <= wr_data;
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    palette_rd_port #(
      .COLOR_W (COLOR_W),
      .DEPTH   (DEPTH),
      .IDX_W   (IDX_W)
    ) u_rd (
      .clk        (clk),
      .rst_n      (rst_n),
      .accept     (rd_valid[k] && accept_ok),
      .idx        (rd_idx[k*IDX_W +: IDX_W]),
      .mem        (mem),
      .wr_fire    (wr_fire),
      .wr_idx     (wr_idx),
      .wr_data    (wr_data),
      .data       (rd_data[k*COLOR_W +: COLOR_W]),
      .data_valid (rd_data_valid[k])
    );
  end

endmodule

// File: tb/tb_palette_lut.sv
// Scoreboard bench for palette_lut (DEPTH=20 so out-of-range and >15 defaults are reachable).
module tb_palette_lut;

  localparam int COLOR_W = 24;
  localparam int DEPTH   = 20;
  localparam int IDX_W   = 5;
  localparam int N_RD    = 2;
`ifdef PALETTE_WR_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    restore;
  logic                    busy;
  logic [N_RD-1:0]         rd_valid;
  logic [N_RD*IDX_W-1:0]   rd_idx;
  logic                    rd_ready;
  logic [N_RD*COLOR_W-1:0] rd_data;
  logic [N_RD-1:0]         rd_data_valid;
  logic                    wr_valid;
  logic [IDX_W-1:0]        wr_idx;
  logic [COLOR_W-1:0]      wr_data;
  logic                    wr_ready;

  int checks = 0;
  int errors = 0;

  logic [23:0] def_tab [DEPTH] = '{
    24'hA056FF, 24'h00FF00, 24'h6700FF, 24'hFFA000,
    24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF,
    24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF,
    24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
    24'h000000, 24'h000000, 24'h000000, 24'h000000
  };
  logic [23:0] mem_m [DEPTH];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];
  logic [23:0] last0, last1;

  palette_lut #(.COLOR_W(COLOR_W), .DEPTH(DEPTH), .N_RD(N_RD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .restore       (restore),
    .busy          (busy),
    .rd_valid      (rd_valid),
    .rd_idx        (rd_idx),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .wr_valid      (wr_valid),
    .wr_idx        (wr_idx),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_of(input logic [IDX_W-1:0] i);
    if (int'(i) < DEPTH) return mem_m[int'(i)];
    return 24'h0;
  endfunction

  // Monitor: pop expected data whenever a channel presents valid, else demand the held value.
  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = '0;
      last1 = '0;
    end else begin
      if (rd_data_valid[0]) begin
        if (q0.size() == 0) chk("rd_ch0_unexpected", 1, 0);
        else chk("rd_ch0", rd_data[23:0], q0.pop_front());
        last0 = rd_data[23:0];
      end else chk("hold_ch0", rd_data[23:0], last0);
      if (rd_data_valid[1]) begin
        if (q1.size() == 0) chk("rd_ch1_unexpected", 1, 0);
        else chk("rd_ch1", rd_data[47:24], q1.pop_front());
        last1 = rd_data[47:24];
      end else chk("hold_ch1", rd_data[47:24], last1);
    end
  end

  // One cycle of stimulus; the model takes the write first so same-index reads see forwarding.
  task automatic cyc(input logic [1:0] v, input logic [IDX_W-1:0] i0, input logic [IDX_W-1:0] i1,
                     input logic w, input logic [IDX_W-1:0] wi, input logic [23:0] wd);
    rd_valid = v;
    rd_idx   = {i1, i0};
    wr_valid = w;
    wr_idx   = wi;
    wr_data  = wd;
    if (w && WR_EN && int'(wi) < DEPTH) mem_m[int'(wi)] = wd;
    if (v[0]) q0.push_back(exp_of(i0));
    if (v[1]) q1.push_back(exp_of(i1));
    @(negedge clk);
    rd_valid = '0;
    wr_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic sweep();
    for (int i = 0; i < DEPTH; i++)
      cyc(2'b11, IDX_W'(i), IDX_W'(DEPTH - 1 - i), 1'b0, '0, '0);
  endtask

  int n;

  initial begin
    rst_n = 1'b0; restore = 1'b0; rd_valid = '0; rd_idx = '0;
    wr_valid = 1'b0; wr_idx = '0; wr_data = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = def_tab[i];
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_valid", rd_data_valid, 0);
    chk("rst_data", rd_data, 0);

    // Requests held through INIT must only be taken once ready.
    rd_valid = 2'b11;
    rd_idx   = {5'd12, 5'd3};
    #2 rst_n = 1'b1;
    wait_ready(n);
    chk("init_cycles", n, DEPTH);
    chk("rd_ready_run", rd_ready, 1);
    q0.push_back(24'hFFA000);
    q1.push_back(24'hFFFFFF);
    @(negedge clk);
    rd_valid = '0;

    cyc(2'b11, 5'd17, 5'd25, 1'b0, '0, '0);
    cyc(2'b11, 5'd0, 5'd0, 1'b0, '0, '0);
    cyc(2'b11, 5'd31, 5'd15, 1'b0, '0, '0);

`ifdef PALETTE_WR_EN
    chk("wr_ready_run", wr_ready, 1);
    cyc(2'b01, 5'd5, 5'd0, 1'b1, 5'd5, 24'h123456);
    cyc(2'b11, 5'd5, 5'd5, 1'b0, '0, '0);
    cyc(2'b10, 5'd0, 5'd25, 1'b1, 5'd25, 24'hABCDEF);
    sweep();
    cyc(2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 24'hABCDEF);
    cyc(2'b01, 5'd0, 5'd0, 1'b0, '0, '0);
`else
    rd_valid = 2'b01; rd_idx = {5'd0, 5'd2};
    wr_valid = 1'b1; wr_idx = 5'd2; wr_data = 24'h000000;
    q0.push_back(24'h6700FF);
    chk("wr_ready_off", wr_ready, 0);
    @(negedge clk);
    rd_valid = '0; wr_valid = 1'b0;
    cyc(2'b11, 5'd2, 5'd2, 1'b0, '0, '0);
`endif

    // Restore with a concurrent write: the write must be dropped.
    restore = 1'b1; wr_valid = 1'b1; wr_idx = 5'd1; wr_data = 24'h111111;
    @(negedge clk);
    restore = 1'b0; wr_valid = 1'b0;
    chk("restore_busy", busy, 1);
    chk("restore_wr_ready", wr_ready, 0);
    wait_ready(n);
    chk("restore_cycles", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) mem_m[i] = def_tab[i];
    cyc(2'b11, 5'd0, 5'd1, 1'b0, '0, '0);
    sweep();

    // Reset arriving partway through INIT.
    restore = 1'b1;
    @(negedge clk);
    restore = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_init_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", rd_data_valid, 0);
    chk("midrst_data", rd_data, 0);
    chk("midrst_busy", busy, 1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_ready(n);
    chk("reinit_cycles", n, DEPTH);
    sweep();

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
